regfile_wr_arbiter: RTL

- Round-robin arbiter that shares the single write port of the 8x8 register bank among NREQ writeback sources (ALU, load unit, immediate/move path).
- Each source presents address and data with a valid/ready handshake.
- The arbiter picks one source per cycle, registers its request, and drives the bank's write enable, write address and write data one cycle later.
- A core-level stall input freezes all grants.

---
 rtl/regfile_wr_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the register bank write port; one registered write per grant.
// Define REGWR_SCOREBOARD_EN to build the per-register pending-write (busy) scoreboard.
module regfile_wr_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = 3,
  parameter int unsigned DW   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 stall,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [DW-1:0]        wr_data,
  output logic [1:0]           grant_id,
  output logic [(2**AW)-1:0]   busy
);

  localparam int unsigned PW    = 2;
  localparam int unsigned NREGS = 2**AW;

  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;
  logic [PW-1:0] grant_id_q;

  logic          win_found_c;
  logic [PW-1:0] win_idx_c;
  logic [AW-1:0] win_addr_c;
  logic [DW-1:0] win_data_c;
  logic          grant_c;
  int unsigned   idx;

  // Scan from rr_ptr upward with wrap; first valid requester wins.
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
    win_addr_c  = '0;
    win_data_c  = '0;
    idx         = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NREQ;
      if (!win_found_c && req_valid[idx]) begin
        win_found_c = 1'b1;
        win_idx_c   = PW'(idx);
        win_addr_c  = req_addr[idx*AW +: AW];
        win_data_c  = req_data[idx*DW +: DW];
      end
    end
  end

  always_comb begin
    grant_c   = win_found_c && !stall && !reset;
    req_ready = '0;
    rr_ptr_d  = rr_ptr_q;
    if (grant_c) begin
      req_ready[win_idx_c] = 1'b1;
      rr_ptr_d = (32'(win_idx_c) + 1 == NREQ) ? '0 : win_idx_c + PW'(1);
    end
  end

  // Output stage: one write cycle per grant, payload held between grants.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      grant_id_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr_en_q  <= grant_c;
      if (grant_c) begin
        wr_addr_q  <= win_addr_c;
        wr_data_q  <= win_data_c;
        grant_id_q <= win_idx_c;
      end
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign grant_id = grant_id_q;

`ifdef REGWR_SCOREBOARD_EN
  logic [NREGS-1:0] busy_q, busy_d;

  // A new grant to the address being written keeps its flag set.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q) busy_d[wr_addr_q] = 1'b0;
    if (grant_c) busy_d[win_addr_c] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy = busy_q;
`else
  assign busy = {NREGS{1'b0}};
`endif

endmodule
